// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory-controller port between two requesters:
//   - port 0 is the instruction fetch.
//   - port 1 is the data load/store.
//   The winning request is registered and the read/write strobe is held for
//   LATENCY cycles. Read data and error are captured on the last access
//   cycle and handed back with a one-cycle ack on the winning port.
//
// Parameters
//   LATENCY     cycles mem_read/mem_write stay high per access (1..15)
//
// Build option
//   ARB_ROUND_ROBIN_EN
//     defined:   ties alternate between the ports.
//     undefined: fixed priority, port 1 wins every tie.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   pN_req/we/addr/wdata           requester N command, held until pN_ack
//   pN_ack/rdata/err               requester N one-cycle completion + response
//   mem_read/mem_write             strobes to the memory controller
//   mem_addr/mem_wdata             registered access address / write data
//   mem_rdata/mem_error            memory controller response
//   busy                           high while an access or response is in flight
module mem_bus_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;       // access cycles remaining after the current one
  logic        win;       // 1 = port 1 owns the current access
  logic        we_q;      // latched direction of the current access
  logic        grant1;    // port 1 wins if a grant happens this cycle
  logic [31:0] cap_rdata; // writes report zero read data

`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_ptr;    // port preferred on the next tie

  always_comb begin
    grant1 = p1_req;
    if (p0_req && p1_req) grant1 = rr_ptr;
  end
`else
  always_comb begin
    grant1 = p1_req;
  end
`endif

  always_comb begin
    cap_rdata = we_q ? 32'h0 : mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'h0;
      win       <= 1'b0;
      we_q      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
      p0_ack    <= 1'b0;
      p0_rdata  <= 32'h0;
      p0_err    <= 1'b0;
      p1_ack    <= 1'b0;
      p1_rdata  <= 32'h0;
      p1_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            win       <= grant1;
            we_q      <= grant1 ? p1_we : p0_we;
            mem_addr  <= grant1 ? p1_addr : p0_addr;
            mem_wdata <= grant1 ? p1_wdata : p0_wdata;
            mem_read  <= grant1 ? ~p1_we : ~p0_we;
            mem_write <= grant1 ? p1_we : p0_we;
            cnt       <= 4'(LATENCY - 1);
            busy      <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= ~grant1;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Only the last access cycle's data and error are reported.
          if (cnt == 4'h0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_ack    <= ~win;
            p1_ack    <= win;
            p0_rdata  <= win ? 32'h0 : cap_rdata;
            p1_rdata  <= win ? cap_rdata : 32'h0;
            p0_err    <= ~win & mem_error;
            p1_err    <= win & mem_error;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        RESP: begin
          p0_ack   <= 1'b0;
          p1_ack   <= 1'b0;
          p0_rdata <= 32'h0;
          p1_rdata <= 32'h0;
          p0_err   <= 1'b0;
          p1_err   <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter.
// The reference model tracks each granted transaction by the edge number of
// its grant and derives strobe, busy and ack timing arithmetically from that.
module tb_mem_bus_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write, mem_error, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_bus_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  // requester-side view of what is being driven
  logic        rq  [2];
  logic        rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rwd   [2];
  assign p0_req = rq[0];  assign p0_we = rwe[0];
  assign p0_addr = raddr[0]; assign p0_wdata = rwd[0];
  assign p1_req = rq[1];  assign p1_we = rwe[1];
  assign p1_addr = raddr[1]; assign p1_wdata = rwd[1];

  // reference model
  bit             active = 0;
  int             g = 0;        // edge number of the current grant
  int             w = 0;        // winning port
  logic           cur_we = 0;
  logic [31:0]    cur_rd = 0;
  logic [LAT-1:0] errpat = '0;
  logic [31:0]    last_addr = 0, last_wd = 0;
`ifdef ARB_ROUND_ROBIN_EN
  int             prefer = 0;
`endif
  bit first = 1, did_rst = 0, rst_hold = 0, stop_new = 0, saturate = 0;
  bit mon_en = 0;

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    chk32(nm, {31'h0, act}, {31'h0, exp});
  endtask

  function automatic bit in_win(int lo, int hi);
    return active && ((cyc - g) >= lo) && ((cyc - g) <= hi);
  endfunction

  task automatic new_req(int p);
    rq[p]    = 1'b1;
    rwe[p]   = 1'($urandom_range(0, 1));
    raddr[p] = $urandom() & 32'hFFFF_FFFC;
    rwd[p]   = $urandom();
  endtask

  // one clock step, called 1 time unit after each rising edge
  task automatic step();
    int n, d, win;
    bit skip;
    n = cyc;
    skip = 0;
    if (rst_hold) begin
      rst = 1'b0;
      rst_hold = 0;
      skip = 1;   // the edge just taken saw reset high
    end else if (!did_rst && n > 2500 && active && (n - g) == 2) begin
      rst = 1'b1;
      #1;
      chk1("rst_async_mem_read", mem_read, 1'b0);
      chk1("rst_async_mem_write", mem_write, 1'b0);
      chk1("rst_async_busy", busy, 1'b0);
      chk32("rst_async_mem_addr", mem_addr, 32'h0);
      void'(q.pop_back());
      active = 0; last_addr = 0; last_wd = 0;
`ifdef ARB_ROUND_ROBIN_EN
      prefer = 0;
`endif
      did_rst = 1;
      rst_hold = 1;
      mem_rdata = $urandom();
      mem_error = 1'($urandom_range(0, 1));
      return;
    end

    d = n - g;
    if (!skip && (!active || d >= LAT + 2) && (rq[0] || rq[1])) begin
      if (rq[0] && rq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = prefer;
`else
        win = 1;
`endif
      end else begin
        win = rq[1] ? 1 : 0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      prefer = 1 - win;
`endif
      active = 1; g = n; w = win;
      cur_we = rwe[win];
      last_addr = raddr[win];
      last_wd = rwd[win];
      cur_rd = first ? 32'hDEAD_BEEF : $urandom();
      first = 0;
      if ($urandom_range(0, 3) == 0) errpat = LAT'(1);   // error on first cycle only
      else errpat = LAT'($urandom());
      q.push_back('{win, g + LAT, cur_we ? 32'h0 : cur_rd, errpat[LAT-1]});
    end
    d = n - g;

    // requester behaviour
    if (active && d == LAT) begin
      if (!stop_new && (saturate || $urandom_range(0, 1) == 1)) new_req(w);
      else rq[w] = 1'b0;
    end
    if (active && d >= 0 && d <= LAT - 1 && $urandom_range(0, 2) == 0) begin
      raddr[w] = $urandom();   // changes after the grant must be ignored
      rwd[w]   = $urandom();
      rwe[w]   = 1'($urandom_range(0, 1));
    end
    for (int p = 0; p < 2; p++)
      if (!rq[p] && !stop_new && (saturate || $urandom_range(0, 3) == 0)) new_req(p);

    // memory controller: real data only on the last access cycle
    if (active && d >= 0 && d <= LAT - 1) begin
      mem_error = errpat[d];
      mem_rdata = (d == LAT - 1) ? cur_rd : (cur_rd ^ ($urandom() | 32'h1));
    end else begin
      mem_error = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
    end
  endtask

  // monitor / scoreboard
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk1("mem_read", mem_read, in_win(0, LAT - 1) && !cur_we);
        chk1("mem_write", mem_write, in_win(0, LAT - 1) && cur_we);
        chk1("busy", busy, in_win(0, LAT));
        chk32("mem_addr", mem_addr, last_addr);
        chk32("mem_wdata", mem_wdata, last_wd);
        if (p0_ack || p1_ack) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL ack_unexpected: got p0_ack=%0b p1_ack=%0b want none (cycle %0d)",
                     p0_ack, p1_ack, cyc);
          end else begin
            e = q.pop_front();
            chk32("ack_port", {30'h0, p1_ack, p0_ack}, (e.port == 1) ? 32'h2 : 32'h1);
            chk32("ack_cycle", cyc, e.cyc);
            chk32("ack_rdata", (e.port == 1) ? p1_rdata : p0_rdata, e.rdata);
            chk1("ack_err", (e.port == 1) ? p1_err : p0_err, e.err);
            chk32("loser_rdata", (e.port == 1) ? p0_rdata : p1_rdata, 32'h0);
            chk1("loser_err", (e.port == 1) ? p0_err : p1_err, 1'b0);
          end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
          total++; bad++;
          $display("FAIL ack_missing: got no ack want port %0d ack at cycle %0d (cycle %0d)",
                   q[0].port, q[0].cyc, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = 32'h0; rwd[p] = 32'h0;
    end
    mem_rdata = 32'h0;
    mem_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_p0_ack", p0_ack, 1'b0);
    chk1("rst_p1_ack", p1_ack, 1'b0);
    chk32("rst_p0_rdata", p0_rdata, 32'h0);
    chk32("rst_p1_rdata", p1_rdata, 32'h0);
    chk1("rst_p0_err", p0_err, 1'b0);
    chk1("rst_p1_err", p1_err, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    // first access: port 0 reads 0x10 alone
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h0000_0010; rwd[0] = 32'h0;
    mon_en = 1;
    for (int it = 0; it < 4000; it++) begin
      @(posedge clk); #1;
      saturate = (cyc > 1200 && cyc < 2200);
      step();
    end
    stop_new = 1;
    saturate = 0;
    repeat (3 * (LAT + 2) + 4) begin
      @(posedge clk); #1;
      step();
    end
    chk32("queue_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer in front of the MCU memory controller. Shares the single memory-controller port between the instruction-fetch requester (port 0) and the data load/store requester (port 1). Registers the winning request, holds the read/write strobes for a fixed access latency, captures read data and error, and returns a one-cycle acknowledge to the winner. Sits between the CPU core and the memory controller; the memory controller and its address decoder are unchanged.

## Interface
- LATENCY, 1: cycles mem_read/mem_write are held per access; legal range 1..15
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- p0_req  in  1  port 0 request; held stable with p0_we/p0_addr/p0_wdata until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_ack  out  1  port 0 completion pulse, one cycle
- p0_rdata  out  32  port 0 read data, valid while p0_ack
- p0_err  out  1  port 0 error, valid while p0_ack
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err: same as port 0, for port 1
- mem_read  out  1  read strobe to memory controller
- mem_write  out  1  write strobe to memory controller
- mem_addr  out  32  registered access address
- mem_wdata  out  32  registered write data
- mem_rdata  in  32  read data from memory controller
- mem_error  in  1  error from memory controller
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if no req, stay. If any req, pick winner (see Configuration), latch winner's we/addr/wdata into mem_* registers, load counter with LATENCY-1, record winner id, go ACCESS.
- ACCESS: mem_read = ~we, mem_write = we. Counter decrements each cycle; at counter==0: capture mem_rdata (reads only; writes capture 0) and mem_error into response registers, go RESP.
- RESP: strobes low; ack=1 on winner port only, with captured rdata/err; loser's ack=0, rdata=0, err=0. Next state IDLE unconditionally.
- Request still high in the IDLE cycle after ack is a new request (requester must drop req after ack if it has nothing further).
- Request changes while not acknowledged: ignored; latched values are used.
- mem_error during any ACCESS cycle other than the last is ignored; only the last-cycle value is reported.
- Reset (any state, including mid-ACCESS): immediately IDLE, access abandoned, no ack issued.
- Reset values: all outputs 0 (acks, errs, rdata, mem_read, mem_write, mem_addr, mem_wdata, busy); round-robin pointer points so port 0 wins first tie.

## Timing
- req sampled high at edge E in IDLE -> mem strobes high for cycles after E through edge E+LATENCY -> ack high for the single cycle between E+LATENCY and E+LATENCY+1.
- Request-to-ack: LATENCY+1 cycles after the sampling edge; back-to-back throughput one access per LATENCY+2 cycles.
- mem_addr/mem_wdata stable for the whole ACCESS state and held through RESP/IDLE until the next grant.
- All outputs registered; no combinational path from p*_req or mem_* inputs to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin on tie; pointer flips to the non-winning port after every grant; single requester always wins regardless of pointer.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, port 1 (data) beats port 0 on tie; no pointer register.

## Test plan
- LATENCY=1, p0 read 0x0000_0010, mem_rdata=0xDEAD_BEEF -> mem_read high 1 cycle with mem_addr=0x10, p0_ack 2 cycles after sampling edge, p0_rdata=0xDEAD_BEEF, p0_err=0.
- LATENCY=3, p1 write 0x2000_0004 data 0x1234_5678 -> mem_write high exactly 3 cycles, mem_wdata=0x1234_5678, p1_ack once, p1_rdata=0.
- Both req held continuously, round-robin build -> grants alternate p0,p1,p0,p1; fixed-priority build -> p1 every grant, p0 starved.
- mem_error=1 on last ACCESS cycle of p0 read -> p0_ack with p0_err=1; mem_error=1 only on first of 3 cycles -> p0_err=0.
- rst asserted mid-ACCESS (LATENCY=4, cycle 2) -> mem_read, busy drop to 0 asynchronously, no ack; after release, held req restarts full 4-cycle access.
- p0_addr changed to 0x40 during ACCESS of 0x10 -> mem_addr stays 0x10 until ack.
